// File: rtl/multi_greeter_pkg.sv
// -----------------------------------------------------------------------------
// multi_greeter_pkg
//   Shared definitions for the multi_greeter serial responder:
//   - default geometry (byte width, message count, max message length)
//   - derived widths (IDX_W for the character counter, MSG_W for message index,
//     ADDR_W for the message ROM)
//   - FSM state encoding
//   - trigger table TRIG, length table LEN and the message text
//   - helpers that clamp lengths and build ROM contents at elaboration time
// -----------------------------------------------------------------------------
package multi_greeter_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_NUM_MSGS    = 4;
    localparam int DEF_MSG_LEN_MAX = 16;

    // Widths are floored at 1 so single-entry configurations still elaborate.
    localparam int IDX_W     = (DEF_MSG_LEN_MAX > 1) ? $clog2(DEF_MSG_LEN_MAX) : 1;
    localparam int MSG_W     = (DEF_NUM_MSGS > 1) ? $clog2(DEF_NUM_MSGS) : 1;
    localparam int ROM_DEPTH = DEF_NUM_MSGS * DEF_MSG_LEN_MAX;
    localparam int ADDR_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Trigger characters: 'h', 'b', 'k', 'q'.
    localparam logic [DEF_DATA_W-1:0] TRIG [DEF_NUM_MSGS] = '{8'h68, 8'h62, 8'h6B, 8'h71};

    // Message lengths in characters. Zero is illegal; values above
    // DEF_MSG_LEN_MAX are clamped.
    localparam int LEN [DEF_NUM_MSGS] = '{14, 5, 4, 3};

    // Message text, right-aligned in a DEF_MSG_LEN_MAX-byte field
    // (first character is the most significant used byte).
    localparam logic [DEF_MSG_LEN_MAX*8-1:0] MSG_TEXT [DEF_NUM_MSGS] = '{
        {16'h0,  "Hello World!\r\n"},
        {88'h0,  "Bye\r\n"},
        {96'h0,  "OK\r\n"},
        {104'h0, "?\r\n"}
    };

    function automatic int clamp_len(input int m);
        int l;
        l = LEN[m];
        if (l > DEF_MSG_LEN_MAX) l = DEF_MSG_LEN_MAX;
        return l;
    endfunction

    // Index of the final character; an illegal zero length degrades to a
    // one-character message so the counter can never run past the slot.
    function automatic logic [IDX_W-1:0] last_idx(input int m);
        int l;
        l = clamp_len(m);
        if (l < 1) l = 1;
        return IDX_W'(l - 1);
    endfunction

    // Character k of message m; slots past the message length read as zero.
    function automatic logic [DEF_DATA_W-1:0] rom_byte(input int m, input int k);
        logic [DEF_MSG_LEN_MAX*8-1:0] t;
        int l;
        l = clamp_len(m);
        // Left-align the text so character k sits at a fixed offset.
        t = MSG_TEXT[m] << ((DEF_MSG_LEN_MAX - l) * 8);
        if (k >= l) return '0;
        return DEF_DATA_W'(t[(DEF_MSG_LEN_MAX-1-k)*8 +: 8]);
    endfunction

endpackage

// File: rtl/multi_greeter_rom.sv
// -----------------------------------------------------------------------------
// msg_rom
//   Registered-output message ROM, ROM_DEPTH x DEF_DATA_W. Message m occupies
//   addresses m*DEF_MSG_LEN_MAX .. m*DEF_MSG_LEN_MAX+DEF_MSG_LEN_MAX-1.
//   Ports:
//     clk      in  clock; letter updates on the rising edge
//     address  in  ADDR_W  read address
//     letter   out DEF_DATA_W  byte at the address sampled on the previous edge
// -----------------------------------------------------------------------------
module msg_rom
    import multi_greeter_pkg::*;
(
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     address,
    output logic [DEF_DATA_W-1:0] letter
);

    logic [DEF_DATA_W-1:0] rom_table [ROM_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
            assign rom_table[gi] = rom_byte(gi / DEF_MSG_LEN_MAX, gi % DEF_MSG_LEN_MAX);
        end
    endgenerate

    always_ff @(posedge clk) begin
        letter <= rom_table[address];
    end

endmodule

// File: rtl/multi_greeter.sv
// -----------------------------------------------------------------------------
// multi_greeter
//   Serial responder between UART RX and TX. A received byte matching a
//   trigger queues its message (one-deep pending slot); the FSM then streams
//   the message out byte by byte over the tx_busy/new_tx handshake.
//   Ports:
//     clk        in   clock
//     rst_n      in   asynchronous active-low reset
//     new_rx     in   rx_data valid strobe
//     rx_data    in   DATA_W received byte
//     tx_busy    in   TX cannot take a byte this cycle
//     new_tx     out  tx_data valid strobe (combinational in SEND)
//     tx_data    out  DATA_W byte to transmit
//     busy       out  FSM not idle
//     msg_done   out  pulse with the last byte of a message
//     trig_drop  out  pulse when a matching trigger was discarded
//   Parameters must match the package defaults the tables are built for.
// -----------------------------------------------------------------------------
module multi_greeter
    import multi_greeter_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_MSGS    = DEF_NUM_MSGS,
    parameter int MSG_LEN_MAX = DEF_MSG_LEN_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_rx,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              new_tx,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              msg_done,
    output logic              trig_drop
);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  char_idx_reg, char_idx_next;
    logic [MSG_W-1:0]  cur_msg_reg, cur_msg_next;
    logic              pend_valid_reg, pend_valid_next;
    logic [MSG_W-1:0]  pend_idx_reg, pend_idx_next;
    logic              trig_drop_reg, trig_drop_next;
    logic [DATA_W-1:0] tx_hold_reg, tx_hold_next;

    logic [NUM_MSGS-1:0] match_vec;
    logic                hit;
    logic [MSG_W-1:0]    hit_idx;
    logic                consume;
    logic                new_tx_c;
    logic                msg_done_c;
    logic [ADDR_W-1:0]   rom_addr;
    logic [DATA_W-1:0]   letter;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MSGS; gi++) begin : g_trig
            assign match_vec[gi] = new_rx && (rx_data == TRIG[gi]);

            always_ff @(posedge clk) begin
                assert (LEN[gi] != 0)
                    else $error("multi_greeter: message %0d has zero length", gi);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        assert (NUM_MSGS == DEF_NUM_MSGS && MSG_LEN_MAX == DEF_MSG_LEN_MAX
                && DATA_W == DEF_DATA_W)
            else $error("multi_greeter: parameters differ from table geometry");
    end

    // Descending scan so the lowest matching index wins on duplicates.
    always_comb begin
        hit_idx = '0;
        for (int i = NUM_MSGS - 1; i >= 0; i--) begin
            if (match_vec[i]) hit_idx = MSG_W'(i);
        end
    end
    assign hit = |match_vec;

    assign rom_addr = ADDR_W'(cur_msg_reg) * ADDR_W'(MSG_LEN_MAX) + ADDR_W'(char_idx_reg);

    msg_rom u_rom (
        .clk     (clk),
        .address (rom_addr),
        .letter  (letter)
    );

    // Next-state / output logic.
    always_comb begin
        state_next    = state_reg;
        char_idx_next = char_idx_reg;
        cur_msg_next  = cur_msg_reg;
        consume       = 1'b0;
        new_tx_c      = 1'b0;
        msg_done_c    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pend_valid_reg) begin
                    consume       = 1'b1;
                    cur_msg_next  = pend_idx_reg;
                    char_idx_next = '0;
                    state_next    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    new_tx_c = 1'b1;
                    if (char_idx_reg == last_idx(int'(cur_msg_reg))) begin
                        msg_done_c = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        char_idx_next = char_idx_reg + IDX_W'(1);
                        state_next    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pending slot: a trigger may replace an entry that IDLE is consuming in
    // the same cycle; otherwise an occupied slot causes the trigger to drop.
    always_comb begin
        pend_valid_next = pend_valid_reg;
        pend_idx_next   = pend_idx_reg;
        trig_drop_next  = 1'b0;
        if (consume) pend_valid_next = 1'b0;
        if (hit) begin
            if (!pend_valid_reg || consume) begin
                pend_valid_next = 1'b1;
                pend_idx_next   = hit_idx;
            end else begin
                trig_drop_next = 1'b1;
            end
        end
    end

    assign tx_hold_next = new_tx_c ? letter : tx_hold_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            char_idx_reg   <= '0;
            cur_msg_reg    <= '0;
            pend_valid_reg <= 1'b0;
            pend_idx_reg   <= '0;
            trig_drop_reg  <= 1'b0;
            tx_hold_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            char_idx_reg   <= char_idx_next;
            cur_msg_reg    <= cur_msg_next;
            pend_valid_reg <= pend_valid_next;
            pend_idx_reg   <= pend_idx_next;
            trig_drop_reg  <= trig_drop_next;
            tx_hold_reg    <= tx_hold_next;
        end
    end

    assign new_tx    = new_tx_c;
    assign msg_done  = msg_done_c;
    assign busy      = (state_reg != ST_IDLE);
    assign trig_drop = trig_drop_reg;
    // The ROM register is not reset, so outside SEND the last sent byte
    // (zero after reset) is shown instead.
    assign tx_data   = (state_reg == ST_SEND) ? letter : tx_hold_reg;

endmodule

// File: tb/tb_multi_greeter.sv
// -----------------------------------------------------------------------------
// tb_multi_greeter
//   Directed bench for multi_greeter: trigger latency, byte pacing, tx_busy
//   back-pressure, pending/drop behaviour, ignored bytes and mid-message reset.
// -----------------------------------------------------------------------------
module tb_multi_greeter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_rx = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       new_tx;
    logic [7:0] tx_data;
    logic       busy;
    logic       msg_done;
    logic       trig_drop;

    int errors = 0;
    int checks = 0;

    multi_greeter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .new_rx    (new_rx),
        .rx_data   (rx_data),
        .tx_busy   (tx_busy),
        .new_tx    (new_tx),
        .tx_data   (tx_data),
        .busy      (busy),
        .msg_done  (msg_done),
        .trig_drop (trig_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Passive monitor, sampled on the falling edge.
    logic [7:0] got_q[$];
    int         cyc_q[$];
    logic       done_q[$];
    int         viol_cnt = 0;
    int         done_cnt = 0;
    int         drop_cnt = 0;
    int         busy_seen = 0;
    logic       last_strobe = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (new_tx) begin
                got_q.push_back(tx_data);
                cyc_q.push_back(cyc);
                done_q.push_back(msg_done);
                $display("tx byte 0x%02h at cycle %0d done=%0b", tx_data, cyc, msg_done);
            end
            if (new_tx && tx_busy) viol_cnt++;
            if (msg_done) done_cnt++;
            if (trig_drop) drop_cnt++;
            if (busy) busy_seen++;
            last_strobe = new_tx;
        end else begin
            last_strobe = 1'b0;
        end
    end

    // Back-pressure generator: tx_busy high for 10 cycles after each strobe.
    logic busy_mode = 1'b0;
    int   busy_left = 0;
    always @(posedge clk) begin
        #1;
        if (!busy_mode) busy_left = 0;
        else if (last_strobe) busy_left = 10;
        else if (busy_left > 0) busy_left--;
        tx_busy = busy_mode && (busy_left > 0);
    end

    logic [7:0] exp_q[$];
    int rx_cyc;

    task automatic exp_add(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        new_rx  = 1'b1;
        rx_data = b;
        rx_cyc  = cyc;
        $display("rx byte 0x%02h at cycle %0d", b, cyc);
        @(posedge clk); #1;
        new_rx  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int t = 0; t < budget && got_q.size() < n; t++) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (new_tx !== 1'b0) begin errors++; $display("FAIL rst_new_tx: got %b want 0", new_tx); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (msg_done !== 1'b0) begin errors++; $display("FAIL rst_msg_done: got %b want 0", msg_done); end
        checks++; if (trig_drop !== 1'b0) begin errors++; $display("FAIL rst_trig_drop: got %b want 0", trig_drop); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        int base, n, lat, bad;
        base = got_q.size();
        exp_q.delete(); exp_add("Hello World!\r\n");
        send_rx(8'h68);
        wait_bytes(base + 14, 100);
        repeat (10) @(posedge clk);
        n = got_q.size() - base;
        checks++; if (n !== 14) begin errors++; $display("FAIL t1_count: got %0d want 14", n); end
        lat = (n > 0) ? cyc_q[base] - rx_cyc : -1;
        checks++; if (lat !== 3) begin errors++; $display("FAIL t1_latency: got %0d want 3", lat); end
        for (int i = 0; i < 14; i++) begin
            logic [7:0] g;
            g = (i < n) ? got_q[base+i] : 8'hxx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL t1_byte[%0d]: got 0x%02h want 0x%02h", i, g, exp_q[i]); end
        end
        bad = 0;
        for (int i = 1; i < n; i++) if (cyc_q[base+i] - cyc_q[base+i-1] != 3) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL t1_spacing: got %0d bad gaps want 0", bad); end
        checks++; if (n < 14 || done_q[base+13] !== 1'b1) begin errors++; $display("FAIL t1_done_last: done not with 14th byte, count %0d", n); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL t1_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int base, n, bad;
        base = got_q.size();
        exp_q.delete(); exp_add("Hello World!\r\n");
        busy_mode = 1'b1;
        send_rx(8'h68);
        wait_bytes(base + 14, 400);
        repeat (20) @(posedge clk);
        busy_mode = 1'b0;
        repeat (2) @(posedge clk);
        n = got_q.size() - base;
        checks++; if (n !== 14) begin errors++; $display("FAIL t2_count: got %0d want 14", n); end
        for (int i = 0; i < 14; i++) begin
            logic [7:0] g;
            g = (i < n) ? got_q[base+i] : 8'hxx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL t2_byte[%0d]: got 0x%02h want 0x%02h", i, g, exp_q[i]); end
        end
        checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL t2_strobe_while_busy: got %0d want 0", viol_cnt); end
        bad = 0;
        for (int i = 1; i < n; i++) if (cyc_q[base+i] - cyc_q[base+i-1] != 11) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL t2_spacing: got %0d gaps not 11 want 0", bad); end
    endtask

    task automatic test_queued();
        int base, n, d0, dd, gap;
        base = got_q.size(); d0 = drop_cnt; dd = done_cnt;
        exp_q.delete(); exp_add("Hello World!\r\n"); exp_add("Bye\r\n");
        send_rx(8'h68);
        wait_bytes(base + 3, 50);
        send_rx(8'h62);
        wait_bytes(base + 19, 300);
        repeat (15) @(posedge clk);
        n = got_q.size() - base;
        checks++; if (n !== 19) begin errors++; $display("FAIL t3_count: got %0d want 19", n); end
        for (int i = 0; i < 19; i++) begin
            logic [7:0] g;
            g = (i < n) ? got_q[base+i] : 8'hxx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL t3_byte[%0d]: got 0x%02h want 0x%02h", i, g, exp_q[i]); end
        end
        checks++; if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL t3_drop: got %0d want 0", drop_cnt - d0); end
        checks++; if (done_cnt - dd !== 2) begin errors++; $display("FAIL t3_done: got %0d want 2", done_cnt - dd); end
        gap = (n > 14) ? cyc_q[base+14] - cyc_q[base+13] : -1;
        checks++; if (gap !== 3) begin errors++; $display("FAIL t3_msg_gap: got %0d want 3", gap); end
    endtask

    task automatic test_drop();
        int base, n, d0;
        base = got_q.size(); d0 = drop_cnt;
        exp_q.delete(); exp_add("Hello World!\r\n"); exp_add("Bye\r\n");
        send_rx(8'h68);
        wait_bytes(base + 2, 50);
        send_rx(8'h62);
        send_rx(8'h68);
        wait_bytes(base + 19, 300);
        repeat (20) @(posedge clk);
        n = got_q.size() - base;
        checks++; if (drop_cnt - d0 !== 1) begin errors++; $display("FAIL t4_drop: got %0d want 1", drop_cnt - d0); end
        checks++; if (n !== 19) begin errors++; $display("FAIL t4_count: got %0d want 19", n); end
        for (int i = 0; i < 19; i++) begin
            logic [7:0] g;
            g = (i < n) ? got_q[base+i] : 8'hxx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL t4_byte[%0d]: got 0x%02h want 0x%02h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_ignore_and_back_to_back();
        int base, n, b0, d0, dd;
        base = got_q.size(); b0 = busy_seen;
        send_rx(8'h78);
        send_rx(8'h00);
        repeat (10) @(posedge clk);
        n = got_q.size() - base;
        checks++; if (n !== 0) begin errors++; $display("FAIL t5_ignored_tx: got %0d strobes want 0", n); end
        checks++; if (busy_seen - b0 !== 0) begin errors++; $display("FAIL t5_ignored_busy: got %0d busy cycles want 0", busy_seen - b0); end
        base = got_q.size(); d0 = drop_cnt; dd = done_cnt;
        exp_q.delete(); exp_add("Bye\r\n"); exp_add("Bye\r\n");
        // Two consecutive "b" strobes: the second lands while IDLE consumes the first.
        @(posedge clk); #1; new_rx = 1'b1; rx_data = 8'h62;
        $display("rx byte 0x62 at cycle %0d", cyc);
        @(posedge clk); #1;
        $display("rx byte 0x62 at cycle %0d", cyc);
        @(posedge clk); #1; new_rx = 1'b0; rx_data = 8'h00;
        wait_bytes(base + 10, 200);
        repeat (15) @(posedge clk);
        n = got_q.size() - base;
        checks++; if (n !== 10) begin errors++; $display("FAIL t5_b2b_count: got %0d want 10", n); end
        checks++; if (drop_cnt - d0 !== 0) begin errors++; $display("FAIL t5_b2b_drop: got %0d want 0", drop_cnt - d0); end
        checks++; if (done_cnt - dd !== 2) begin errors++; $display("FAIL t5_b2b_done: got %0d want 2", done_cnt - dd); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] g;
            g = (i < n) ? got_q[base+i] : 8'hxx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL t5_byte[%0d]: got 0x%02h want 0x%02h", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_message();
        int base, n;
        base = got_q.size();
        exp_q.delete(); exp_add("Hello"); exp_add("Bye\r\n");
        send_rx(8'h68);
        wait_bytes(base + 5, 100);
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (new_tx) break;
        end
        checks++; if (new_tx !== 1'b1) begin errors++; $display("FAIL t6_pre_strobe: got %b want 1", new_tx); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (new_tx !== 1'b0) begin errors++; $display("FAIL t6_async_new_tx: got %b want 0", new_tx); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL t6_async_tx_data: got %h want 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_async_busy: got %b want 0", busy); end
        checks++; if (msg_done !== 1'b0) begin errors++; $display("FAIL t6_async_msg_done: got %b want 0", msg_done); end
        checks++; if (trig_drop !== 1'b0) begin errors++; $display("FAIL t6_async_trig_drop: got %b want 0", trig_drop); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        n = got_q.size() - base;
        checks++; if (n !== 5) begin errors++; $display("FAIL t6_no_strobes_after_reset: got %0d want 5", n); end
        send_rx(8'h62);
        wait_bytes(base + 10, 100);
        repeat (10) @(posedge clk);
        n = got_q.size() - base;
        checks++; if (n !== 10) begin errors++; $display("FAIL t6_count: got %0d want 10", n); end
        for (int i = 0; i < 10; i++) begin
            logic [7:0] g;
            g = (i < n) ? got_q[base+i] : 8'hxx;
            checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL t6_byte[%0d]: got 0x%02h want 0x%02h", i, g, exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_queued();
        test_drop();
        test_ignore_and_back_to_back();
        test_reset_mid_message();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
